// File: rtl/des_block_loader.sv
// Assembles a KEY and a DATA block chunk-by-chunk from switch entry on a push-button,
// with random-access chunk editing, a review state and a start/done handshake to the DES core.
module des_block_loader #(
    parameter int unsigned CHUNK_W    = 16,
    parameter int unsigned NUM_CHUNKS = 4,
    parameter int unsigned SEL_W      = 2,
    localparam int unsigned BW        = CHUNK_W * NUM_CHUNKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CHUNK_W-1:0] user_input,
    input  logic               send_n,
    input  logic               edit_en,
    input  logic [SEL_W-1:0]   edit_sel,
    input  logic               field_sel,
    input  logic               go,
    input  logic               core_ready,
    output logic               core_start,
    input  logic               core_done,
    output logic [BW-1:0]      key_out,
    output logic [BW-1:0]      data_out,
    output logic [CHUNK_W-1:0] disp_word,
    output logic [2:0]         state_out,
    output logic [SEL_W:0]     chunk_cnt
);

    typedef enum logic [2:0] {
        StInKey  = 3'd0,
        StInData = 3'd1,
        StReview = 3'd2,
        StStart  = 3'd3,
        StWait   = 3'd4,
        StDone   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [BW-1:0]      key_q, key_d;
    logic [BW-1:0]      data_q, data_d;
    logic [SEL_W:0]     cnt_q, cnt_d;
    logic               send_q, go_q;

    logic               press, go_edge, sel_ok;
    logic               wr_en, wr_data;
    logic [31:0]        wr_idx, sel_idx;

    // Chunk 0 is the most significant chunk of the block.
    function automatic logic [BW-1:0] put_chunk(input logic [BW-1:0] v, input logic [31:0] idx,
                                                input logic [CHUNK_W-1:0] c);
        logic [BW-1:0] r;
        r = v;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == i) r[BW-1-i*CHUNK_W -: CHUNK_W] = c;
        end
        return r;
    endfunction

    function automatic logic [CHUNK_W-1:0] get_chunk(input logic [BW-1:0] v,
                                                     input logic [31:0] idx);
        logic [CHUNK_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == i) r = v[BW-1-i*CHUNK_W -: CHUNK_W];
        end
        return r;
    endfunction

    assign press   = send_q & ~send_n;
    assign go_edge = go & ~go_q;
    assign sel_idx = 32'(edit_sel);
    assign sel_ok  = sel_idx < NUM_CHUNKS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInKey;
            key_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            send_q  <= 1'b1;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            send_q  <= send_n;
            go_q    <= go;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_data = 1'b0;
        wr_idx  = '0;
        unique case (state_q)
            StInKey, StInData: begin
                wr_data = (state_q == StInData);
                if (press) begin
                    if (edit_en) begin
                        wr_en  = sel_ok;
                        wr_idx = sel_idx;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = 32'(cnt_q);
                        if (cnt_q == (SEL_W+1)'(NUM_CHUNKS - 1)) begin
                            cnt_d   = '0;
                            state_d = (state_q == StInKey) ? StInData : StReview;
                        end else begin
                            cnt_d = cnt_q + (SEL_W+1)'(1);
                        end
                    end
                end
            end
            StReview: begin
                // A go edge always swallows a coincident press.
                if (go_edge) begin
                    if (core_ready) state_d = StStart;
                end else if (press) begin
                    wr_en   = sel_ok;
                    wr_data = field_sel;
                    wr_idx  = sel_idx;
                end
            end
            StStart: state_d = StWait;
            StWait:  if (core_done) state_d = StDone;
            StDone:  if (go_edge) state_d = StReview;
            default: state_d = StInKey;
        endcase
        if (wr_en) begin
            if (wr_data) data_d = put_chunk(data_q, wr_idx, user_input);
            else         key_d  = put_chunk(key_q, wr_idx, user_input);
        end
    end

    always_comb begin
        core_start = (state_q == StStart);
        state_out  = state_q;
        key_out    = key_q;
        data_out   = data_q;
        chunk_cnt  = cnt_q;
        disp_word  = get_chunk(field_sel ? data_q : key_q, sel_idx);
    end

endmodule
